// File: rtl/fetch_stage_if.sv
// Instruction-port request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic        inst_rdata_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_ready,
    input  inst_rdata_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_ready,
    output inst_rdata_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: single-outstanding fetch with a hold buffer for
// stalled responses, and delayed (branch-delay-slot) redirects.
//
// state  | meaning
// S_REQ  | request presented at pcF, waiting for memory to accept
// S_WAIT | request accepted, waiting for read data
// S_HOLD | read data captured in hold buffer, waiting for stallF to drop
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               flushD,
  input  logic               pcsrcD,
  input  logic [31:0]        pcbranchD,
  input  logic               jumpD,
  input  logic [31:0]        pcjumpD,
  fetch_stage_if.master      imem,
  output logic               fetch_stall,
  output logic [31:0]        instrD,
  output logic [31:0]        pcD,
  output logic [31:0]        pcplus4D,
  output logic               validD
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pcD_q, pcD_d;
  logic [31:0] pcplus4D_q, pcplus4D_d;
  logic        validD_q, validD_d;
  logic        req_q;

  logic        avail, consume, redir_now;
  logic [31:0] word, redir_tgt, pc_plus4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    instrD_d   = instrD_q;
    pcD_d      = pcD_q;
    pcplus4D_d = pcplus4D_q;
    validD_d   = validD_q;

    redir_now = ~stallD & (jumpD | pcsrcD);
    redir_tgt = jumpD ? pcjumpD : pcbranchD;
    avail     = ((state_q == S_WAIT) & imem.inst_rdata_ok) | (state_q == S_HOLD);
    word      = (state_q == S_HOLD) ? hold_q : imem.inst_rdata;
    consume   = avail & ~stallF;
    pc_plus4  = pc_q + 32'd4;

    case (state_q)
      S_REQ:  if (imem.inst_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.inst_rdata_ok) begin
          if (stallF) begin
            state_d = S_HOLD;
            hold_d  = imem.inst_rdata;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: if (!stallF) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    // The word being consumed is the delay slot; the redirect applies to the next fetch.
    if (consume) begin
      pend_d = 1'b0;
      if (redir_now)   pc_d = redir_tgt;
      else if (pend_q) pc_d = tgt_q;
      else             pc_d = pc_plus4;
    end else if (redir_now) begin
      pend_d = 1'b1;
      tgt_d  = redir_tgt;
    end

    if (flushD) begin
      instrD_d   = 32'h0;
      pcD_d      = 32'h0;
      pcplus4D_d = 32'h0;
      validD_d   = 1'b0;
    end else if (!stallD) begin
      if (consume) begin
        instrD_d   = word;
        pcD_d      = pc_q;
        pcplus4D_d = pc_plus4;
        validD_d   = 1'b1;
      end else begin
        instrD_d = 32'h0;
        validD_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      req_q      <= 1'b1;
      pc_q       <= RESET_PC;
      hold_q     <= 32'h0;
      pend_q     <= 1'b0;
      tgt_q      <= 32'h0;
      instrD_q   <= 32'h0;
      pcD_q      <= 32'h0;
      pcplus4D_q <= 32'h0;
      validD_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= (state_d == S_REQ);
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      tgt_q      <= tgt_d;
      instrD_q   <= instrD_d;
      pcD_q      <= pcD_d;
      pcplus4D_q <= pcplus4D_d;
      validD_q   <= validD_d;
    end
  end

  assign imem.inst_req  = req_q;
  assign imem.inst_addr = pc_q;
  assign fetch_stall    = ~avail;
  assign instrD         = instrD_q;
  assign pcD            = pcD_q;
  assign pcplus4D       = pcplus4D_q;
  assign validD         = validD_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table for plain fetch and stallF hold,
// hand-written sequences for redirects, IF/ID flush/stall, reset and PC wrap.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, flushD, pcsrcD, jumpD;
  logic [31:0] pcbranchD, pcjumpD;
  logic        fetch_stall, validD;
  logic [31:0] instrD, pcD, pcplus4D;
  logic [31:0] mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .jumpD(jumpD), .pcjumpD(pcjumpD),
    .imem(bus.master), .fetch_stall(fetch_stall), .instrD(instrD), .pcD(pcD),
    .pcplus4D(pcplus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  // Memory model returns the word for the last accepted address; junk otherwise.
  assign bus.inst_rdata = bus.inst_rdata_ok ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        stallF;
    logic        ready;
    logic        rok;
    logic        push;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_fs;
    logic        exp_v;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.instr = mem_word(pc);
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    sb.push_back(e);
  endtask

  // One clock; afterwards any fresh IF/ID load is checked against the scoreboard.
  task automatic cyc();
    logic ld;
    exp_t e;
    ld = ~flushD & ~stallD & ~rst;
    if (bus.inst_req && bus.inst_ready) mem_addr = bus.inst_addr;
    @(posedge clk);
    #1;
    if (ld && validD) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow got pcD %h expected no load", pcD);
      end else begin
        e = sb.pop_front();
        chk("sb_instrD", instrD, e.instr);
        chk("sb_pcD", pcD, e.pc);
        chk("sb_pcplus4D", pcplus4D, e.pc4);
      end
    end
  endtask

  task automatic fetch_word(input logic [31:0] pc, input logic jmp, input logic [31:0] jt,
                            input logic br, input logic [31:0] bt);
    bus.inst_ready = 1'b1;
    bus.inst_rdata_ok = 1'b0;
    #1;
    chk("fw_req", bus.inst_req, 1'b1);
    chk("fw_addr", bus.inst_addr, pc);
    cyc();
    bus.inst_ready = 1'b0;
    bus.inst_rdata_ok = 1'b1;
    jumpD = jmp; pcjumpD = jt; pcsrcD = br; pcbranchD = bt;
    #1;
    chk("fw_fetch_stall", fetch_stall, 1'b0);
    push(pc);
    cyc();
    bus.inst_rdata_ok = 1'b0;
    jumpD = 1'b0; pcjumpD = 32'h0; pcsrcD = 1'b0; pcbranchD = 32'h0;
  endtask

  initial begin
    //           stF rdy rok psh req addr          fs  v
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h04, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h08, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0C, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 1'b1};

    rst = 1'b1;
    stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    pcsrcD = 1'b0; pcbranchD = 32'h0; jumpD = 1'b0; pcjumpD = 32'h0;
    bus.inst_ready = 1'b0; bus.inst_rdata_ok = 1'b0;
    mem_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_req", bus.inst_req, 1'b1);
    chk("rst_addr", bus.inst_addr, 32'h0);
    chk("rst_fetch_stall", fetch_stall, 1'b1);
    chk("rst_validD", validD, 1'b0);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_pcD", pcD, 32'h0);
    chk("rst_pcplus4D", pcplus4D, 32'h0);

    for (int i = 0; i < 15; i++) begin
      stallF = vecs[i].stallF;
      bus.inst_ready = vecs[i].ready;
      bus.inst_rdata_ok = vecs[i].rok;
      #1;
      chk($sformatf("vec%0d_req", i), bus.inst_req, vecs[i].exp_req);
      chk($sformatf("vec%0d_addr", i), bus.inst_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_fetch_stall", i), fetch_stall, vecs[i].exp_fs);
      chk($sformatf("vec%0d_validD", i), validD, vecs[i].exp_v);
      if (vecs[i].push) push(vecs[i].exp_addr);
      cyc();
    end
    stallF = 1'b0;

    for (int a = 32'h14; a <= 32'h20; a += 4) fetch_word(a, 1'b0, 32'h0, 1'b0, 32'h0);

    // Taken branch while 0x24 is in flight: 0x24 still completes.
    bus.inst_ready = 1'b1;
    #1;
    chk("br_addr24", bus.inst_addr, 32'h24);
    cyc();
    bus.inst_ready = 1'b0;
    pcsrcD = 1'b1; pcbranchD = 32'h100;
    #1;
    chk("br_wait_fetch_stall", fetch_stall, 1'b1);
    cyc();
    pcsrcD = 1'b0; pcbranchD = 32'h0;
    bus.inst_rdata_ok = 1'b1;
    #1;
    push(32'h24);
    cyc();
    bus.inst_rdata_ok = 1'b0;

    // Jump and branch together on the consume cycle: jump wins.
    fetch_word(32'h100, 1'b1, 32'h200, 1'b1, 32'h100);

    stallD = 1'b1;
    #1;
    chk("jmp_addr", bus.inst_addr, 32'h200);
    chk("jmp_req", bus.inst_req, 1'b1);
    cyc();
    chk("stallD_validD", validD, 1'b1);
    chk("stallD_instrD", instrD, mem_word(32'h100));
    flushD = 1'b1;
    cyc();
    chk("flush_instrD", instrD, 32'h0);
    chk("flush_validD", validD, 1'b0);
    flushD = 1'b0; stallD = 1'b0;

    // Reset while waiting for data, then a late response must be dropped.
    bus.inst_ready = 1'b1;
    #1;
    chk("pre_rst_addr", bus.inst_addr, 32'h200);
    cyc();
    bus.inst_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_addr", bus.inst_addr, 32'h0);
    chk("midrst_req", bus.inst_req, 1'b1);
    chk("midrst_validD", validD, 1'b0);
    bus.inst_rdata_ok = 1'b1;
    #1;
    chk("late_ok_fetch_stall", fetch_stall, 1'b1);
    cyc();
    bus.inst_rdata_ok = 1'b0;
    chk("late_ok_req", bus.inst_req, 1'b1);
    chk("late_ok_addr", bus.inst_addr, 32'h0);
    chk("late_ok_validD", validD, 1'b0);

    // PC wrap-around at the top of the address space.
    fetch_word(32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    fetch_word(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("wrap_addr", bus.inst_addr, 32'h0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
